fsm_mem_init_gen: RTL and testbench

Parametrised memory-initialisation sequencer for the RC4 datapath. On a start request it writes DEPTH consecutive words, addresses 0..DEPTH-1, into a single-port RAM. The data comes from a selectable pattern (identity, constant, descending, XOR), with an optional programmable gap between writes. It replaces the fixed 256-entry identity initialiser and supports re-triggering through a 4-phase start/done handshake.

---
 rtl/fsm_mem_init_gen.sv | 138 +++++++++++++
 tb/tb_fsm_mem_init_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_mem_init_gen.sv
// Memory-initialisation sequencer: writes DEPTH pattern words to addresses 0..DEPTH-1 with an optional gap.
// Optional abort input is enabled by defining FSM_MEM_INIT_ABORT_EN.
module fsm_mem_init_gen #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int WR_GAP = 0
) (
    input  logic              CLOCK_50,
    input  logic              rst,
`ifdef FSM_MEM_INIT_ABORT_EN
    input  logic              abort,
`endif
    input  logic              In_Start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data,
    output logic              wren,
    output logic              busy,
    output logic              Init_Finish
);

    localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic [1:0]        mode_q, mode_n;
    logic [DATA_W-1:0] fill_q, fill_n;
    logic              wren_n, busy_n, fin_n;
    logic              abort_i;

`ifdef FSM_MEM_INIT_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] f,
                                                  input logic [ADDR_W-1:0] a);
        logic [31:0]       a32;
        logic [DATA_W-1:0] a_d;
        a32 = 32'(a);
        a_d = DATA_W'(a32);
        case (m)
            2'b00:   pattern = a_d;
            2'b01:   pattern = f;
            2'b10:   pattern = DATA_W'(32'(DEPTH - 1) - a32);
            default: pattern = a_d ^ f;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        addr_n  = Address;
        data_n  = Data;
        gap_n   = gap_cnt;
        mode_n  = mode_q;
        fill_n  = fill_q;
        wren_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (In_Start) begin
                    // first word uses the live inputs; the latched copies take over afterwards
                    mode_n  = mode;
                    fill_n  = fill_value;
                    addr_n  = '0;
                    data_n  = pattern(mode, fill_value, '0);
                    wren_n  = 1'b1;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort_i) begin
                    state_n = S_IDLE;
                end else if (Address == LAST) begin
                    state_n = S_DONE;
                end else if (WR_GAP == 0) begin
                    addr_n = Address + 1'b1;
                    data_n = pattern(mode_q, fill_q, addr_n);
                    wren_n = 1'b1;
                end else begin
                    gap_n   = GAP_W'(WR_GAP);
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (abort_i) begin
                    state_n = S_IDLE;
                end else if (gap_cnt == GAP_W'(1)) begin
                    addr_n  = Address + 1'b1;
                    data_n  = pattern(mode_q, fill_q, addr_n);
                    wren_n  = 1'b1;
                    state_n = S_WRITE;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            S_DONE: begin
                if (!In_Start) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n == S_WRITE) || (state_n == S_GAP);
        fin_n  = (state_n == S_DONE);
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            Address     <= '0;
            Data        <= '0;
            wren        <= 1'b0;
            busy        <= 1'b0;
            Init_Finish <= 1'b0;
            gap_cnt     <= '0;
            mode_q      <= '0;
            fill_q      <= '0;
        end else begin
            state       <= state_n;
            Address     <= addr_n;
            Data        <= data_n;
            wren        <= wren_n;
            busy        <= busy_n;
            Init_Finish <= fin_n;
            gap_cnt     <= gap_n;
            mode_q      <= mode_n;
            fill_q      <= fill_n;
        end
    end

endmodule

// File: tb/tb_fsm_mem_init_gen.sv
// Randomised bench for fsm_mem_init_gen: four parameter sets checked against a cycle-formula reference model.
module tb_fsm_mem_init_gen;

    logic       clk;
    logic       rst;
    logic       abort_s;
    logic       start  [4];
    logic [1:0] mode_s [4];
    logic [7:0] fill_s [4];
    logic [7:0] a0, a1;
    logic [3:0] a2;
    logic       a3;
    logic [7:0] data_o [4];
    logic       wren_o [4];
    logic       busy_o [4];
    logic       fin_o  [4];

    int n_checks = 0;
    int n_fail   = 0;

    fsm_mem_init_gen #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WR_GAP(0)) u_d0 (
        .CLOCK_50(clk), .rst(rst),
`ifdef FSM_MEM_INIT_ABORT_EN
        .abort(abort_s),
`endif
        .In_Start(start[0]), .mode(mode_s[0]), .fill_value(fill_s[0]),
        .Address(a0), .Data(data_o[0]), .wren(wren_o[0]), .busy(busy_o[0]), .Init_Finish(fin_o[0]));

    fsm_mem_init_gen #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WR_GAP(2)) u_d1 (
        .CLOCK_50(clk), .rst(rst),
`ifdef FSM_MEM_INIT_ABORT_EN
        .abort(abort_s),
`endif
        .In_Start(start[1]), .mode(mode_s[1]), .fill_value(fill_s[1]),
        .Address(a1), .Data(data_o[1]), .wren(wren_o[1]), .busy(busy_o[1]), .Init_Finish(fin_o[1]));

    fsm_mem_init_gen #(.ADDR_W(4), .DATA_W(8), .DEPTH(10), .WR_GAP(0)) u_d2 (
        .CLOCK_50(clk), .rst(rst),
`ifdef FSM_MEM_INIT_ABORT_EN
        .abort(abort_s),
`endif
        .In_Start(start[2]), .mode(mode_s[2]), .fill_value(fill_s[2]),
        .Address(a2), .Data(data_o[2]), .wren(wren_o[2]), .busy(busy_o[2]), .Init_Finish(fin_o[2]));

    fsm_mem_init_gen #(.ADDR_W(1), .DATA_W(8), .DEPTH(1), .WR_GAP(1)) u_d3 (
        .CLOCK_50(clk), .rst(rst),
`ifdef FSM_MEM_INIT_ABORT_EN
        .abort(abort_s),
`endif
        .In_Start(start[3]), .mode(mode_s[3]), .fill_value(fill_s[3]),
        .Address(a3), .Data(data_o[3]), .wren(wren_o[3]), .busy(busy_o[3]), .Init_Finish(fin_o[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int dep_of(input int k);
        case (k)
            0, 1:    return 256;
            2:       return 10;
            default: return 1;
        endcase
    endfunction

    function automatic int gap_of(input int k);
        case (k)
            1:       return 2;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    function int addr_of(input int k);
        case (k)
            0:       return int'(a0);
            1:       return int'(a1);
            2:       return int'(a2);
            default: return int'(a3);
        endcase
    endfunction

    // expected write data for word n of a DEPTH-d run
    function automatic int pat(input logic [1:0] m, input int f, input int n, input int d);
        case (m)
            2'b00:   return n & 255;
            2'b01:   return f & 255;
            2'b10:   return (d - 1 - n) & 255;
            default: return (n ^ f) & 255;
        endcase
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input int k, input string tag);
        check_eq({tag, "_wren"}, int'(wren_o[k]), 0);
        check_eq({tag, "_busy"}, int'(busy_o[k]), 0);
        check_eq({tag, "_fin"}, int'(fin_o[k]), 0);
    endtask

    // One run on instance k; cut>0 stops after checking that cycle, leaving the run in flight.
    task automatic run(input int k, input logic [1:0] m, input logic [7:0] f,
                       input bit hold, input int cut);
        int d, g, total, pulses, n;
        bit w;
        d      = dep_of(k);
        g      = gap_of(k);
        total  = 2 + (d - 1) * (g + 1);
        pulses = 0;
        @(negedge clk);
        start[k]  = 1'b1;
        mode_s[k] = m;
        fill_s[k] = f;
        @(posedge clk);
        for (int c = 1; c <= total; c++) begin
            if (c > 1) @(posedge clk);
            #1;
            n = (c - 1) / (g + 1);
            w = ((c - 1) % (g + 1) == 0) && (n < d);
            check_eq("wren", int'(wren_o[k]), int'(w));
            if (wren_o[k]) pulses++;
            if (w) begin
                check_eq("address", addr_of(k), n);
                check_eq("data", int'(data_o[k]), pat(m, int'(f), n, d));
            end
            check_eq("addr_range", int'(addr_of(k) < d), 1);
            check_eq("busy", int'(busy_o[k]), int'(c < total));
            check_eq("init_finish", int'(fin_o[k]), int'(c == total));
            if (c == cut) return;
            if (c < total) begin
                start[k]  = 1'($urandom_range(0, 1));
                mode_s[k] = 2'($urandom);
                fill_s[k] = 8'($urandom);
            end
        end
        check_eq("pulse_count", pulses, d);
        start[k] = hold;
        if (hold) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                check_eq("done_hold_fin", int'(fin_o[k]), 1);
                check_eq("done_hold_wren", int'(wren_o[k]), 0);
            end
        end
        start[k] = 1'b0;
        @(posedge clk);
        #1;
        check_quiet(k, "done_release");
    endtask

    initial begin
        int k;
        rst     = 1'b1;
        abort_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start[i]  = 1'b0;
            mode_s[i] = 2'b00;
            fill_s[i] = 8'h00;
        end
        #12;
        for (int i = 0; i < 4; i++) begin
            check_eq("reset_addr", addr_of(i), 0);
            check_eq("reset_data", int'(data_o[i]), 0);
            check_quiet(i, "reset");
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run(0, 2'b00, 8'($urandom), 1'b0, 0);
        run(1, 2'b01, 8'hA5, 1'b0, 0);
        run(2, 2'b10, 8'($urandom), 1'b0, 0);
        run(3, 2'($urandom), 8'($urandom), 1'b0, 0);
        run(0, 2'b00, 8'h00, 1'b1, 0);
        run(0, 2'b11, 8'h0F, 1'b0, 0);

        repeat (3) begin
            k = int'($urandom_range(0, 3));
            run(k, 2'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        // asynchronous reset mid-run while Address is 100
        run(0, 2'b00, 8'h00, 1'b0, 101);
        start[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_addr", addr_of(0), 0);
        check_eq("async_rst_data", int'(data_o[0]), 0);
        check_quiet(0, "async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_quiet(0, "post_rst_idle");
        end
        run(2, 2'($urandom), 8'($urandom), 1'b0, 0);

`ifdef FSM_MEM_INIT_ABORT_EN
        run(0, 2'b00, 8'h00, 1'b0, 51);
        start[0] = 1'b0;
        abort_s  = 1'b1;
        @(posedge clk);
        #1;
        abort_s = 1'b0;
        check_quiet(0, "abort");
        repeat (300) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_wren", int'(wren_o[0]), 0);
            check_eq("abort_no_fin", int'(fin_o[0]), 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
